// File: rtl/dm_wait_ctrl.sv
// Multi-cycle word data memory with programmable wait states and req/ack handshake.
// Optional misalignment flagging is enabled by defining DM_ALIGN_CHECK_EN.
module dm_wait_ctrl #(
    parameter int unsigned ADDR_BITS   = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                 state_q;
    logic [3:0]             cnt_q;
    logic                   we_q;
    logic [ADDR_BITS-1:0]   idx_q;
    logic [31:0]            wdata_q;
    logic [31:0]            rdata_q;
    logic                   ack_q;
    logic                   busy_q;
    logic                   err_q;
    logic [31:0]            mem_q [0:(1 << ADDR_BITS) - 1];
    logic                   misalign;
    logic                   commit;
    logic                   unused_addr;

`ifdef DM_ALIGN_CHECK_EN
    assign misalign = (address[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign unused_addr = ^{address[31:ADDR_BITS+2], address[1:0]};
    assign commit      = (state_q == S_WAIT) && (cnt_q == 4'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        idx_q   <= address[ADDR_BITS+1:2];
                        wdata_q <= data_in;
                        cnt_q   <= WAIT_CYCLES[3:0];
                        busy_q  <= 1'b1;
                        if (misalign) begin
                            state_q <= S_DONE;
                            ack_q   <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        if (!we_q) begin
                            rdata_q <= mem_q[idx_q];
                        end
                        state_q <= S_DONE;
                        ack_q   <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset; a reset on the commit edge still suppresses the write.
    always_ff @(posedge clock) begin
        if (!reset && commit && we_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign data_out = rdata_q;
    assign ack      = ack_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_dm_wait_ctrl.sv
// Directed self-checking bench for dm_wait_ctrl: one instance with WAIT_CYCLES=2, one with 0.
module tb_dm_wait_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req2  = 1'b0;
    logic        req0  = 1'b0;
    logic        we    = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] data_in = '0;
    logic [31:0] dout2, dout0;
    logic        ack2, ack0, busy2, busy0, err2, err0;

    int vec     = 0;
    int miscomp = 0;

    always #5 clock = ~clock;

    dm_wait_ctrl #(.ADDR_BITS(10), .WAIT_CYCLES(2)) dut2 (
        .clock(clock), .reset(reset), .req(req2), .we(we), .address(address),
        .data_in(data_in), .data_out(dout2), .ack(ack2), .busy(busy2), .err(err2)
    );

    dm_wait_ctrl #(.ADDR_BITS(10), .WAIT_CYCLES(0)) dut0 (
        .clock(clock), .reset(reset), .req(req0), .we(we), .address(address),
        .data_in(data_in), .data_out(dout0), .ack(ack0), .busy(busy0), .err(err0)
    );

    // One access: lat = edges after the accepting edge until ack is seen (-1 on timeout),
    // bcnt = cycles with busy high up to and including the ack cycle.
    task automatic access(input bit sel0, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input bit perturb, output logic [31:0] rd, output int lat,
                          output int bcnt, output logic e);
        logic a_s, b_s;
        @(posedge clock); #1;
        we = w; address = a; data_in = d;
        if (sel0) req0 = 1'b1; else req2 = 1'b1;
        @(posedge clock); #1;
        req0 = 1'b0; req2 = 1'b0;
        if (perturb) begin
            data_in = 32'h2222_2222;
            address = a + 32'd4;
            we      = ~w;
        end
        lat = -1; bcnt = 0; rd = 'x; e = 'x;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            a_s = sel0 ? ack0 : ack2;
            b_s = sel0 ? busy0 : busy2;
            if (b_s) bcnt++;
            if (a_s) begin
                lat = n - 1;
                rd  = sel0 ? dout0 : dout2;
                e   = sel0 ? err0 : err2;
                break;
            end
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            vec++;
            if ({dout2, ack2, busy2, err2} !== 35'd0) begin
                miscomp++;
                $display("FAIL reset_idle2 cyc %0d: got dout=%h ack=%b busy=%b err=%b expected all 0",
                         i, dout2, ack2, busy2, err2);
            end
            vec++;
            if ({dout0, ack0, busy0, err0} !== 35'd0) begin
                miscomp++;
                $display("FAIL reset_idle0 cyc %0d: got dout=%h ack=%b busy=%b err=%b expected all 0",
                         i, dout0, ack0, busy0, err0);
            end
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; int lat, bc; logic e;
        access(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, rd, lat, bc, e);
        vec++; if (lat !== 3) begin miscomp++; $display("FAIL st_lat: got %0d expected 3", lat); end
        vec++; if (bc !== 4) begin miscomp++; $display("FAIL st_busy: got %0d expected 4", bc); end
        vec++; if (rd !== 32'h0) begin miscomp++; $display("FAIL st_dout_hold: got %h expected 00000000", rd); end
        vec++; if (e !== 1'b0) begin miscomp++; $display("FAIL st_err: got %b expected 0", e); end
        access(1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b0, rd, lat, bc, e);
        vec++; if (lat !== 3) begin miscomp++; $display("FAIL ld_lat: got %0d expected 3", lat); end
        vec++; if (bc !== 4) begin miscomp++; $display("FAIL ld_busy: got %0d expected 4", bc); end
        vec++; if (rd !== 32'hDEAD_BEEF) begin miscomp++; $display("FAIL ld_data: got %h expected deadbeef", rd); end
        vec++; if (busy2 !== 1'b0) begin miscomp++; $display("FAIL idle_after: got busy=%b expected 0", busy2); end
    endtask

    task automatic test_input_change();
        logic [31:0] rd; int lat, bc; logic e;
        access(1'b0, 1'b1, 32'h0000_0024, 32'h55AA_55AA, 1'b0, rd, lat, bc, e);
        access(1'b0, 1'b1, 32'h0000_0020, 32'h1111_1111, 1'b1, rd, lat, bc, e);
        vec++; if (lat !== 3) begin miscomp++; $display("FAIL chg_lat: got %0d expected 3", lat); end
        access(1'b0, 1'b0, 32'h0000_0020, 32'h0, 1'b0, rd, lat, bc, e);
        vec++; if (rd !== 32'h1111_1111) begin miscomp++; $display("FAIL chg_ld20: got %h expected 11111111", rd); end
        access(1'b0, 1'b0, 32'h0000_0024, 32'h0, 1'b0, rd, lat, bc, e);
        vec++; if (rd !== 32'h55AA_55AA) begin miscomp++; $display("FAIL chg_ld24: got %h expected 55aa55aa", rd); end
    endtask

    task automatic test_reset_during_wait();
        logic [31:0] rd; int lat, bc; logic e;
        logic saw_ack, saw_busy;
        access(1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678, 1'b0, rd, lat, bc, e);
        @(posedge clock); #1;
        we = 1'b1; address = 32'h0000_0040; data_in = 32'hCAFE_F00D; req2 = 1'b1;
        @(posedge clock); #1;
        req2 = 1'b0; reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        saw_ack = 1'b0; saw_busy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            saw_ack  |= ack2;
            saw_busy |= busy2;
        end
        vec++; if (saw_ack !== 1'b0) begin miscomp++; $display("FAIL rst_noack: got %b expected 0", saw_ack); end
        vec++; if (saw_busy !== 1'b0) begin miscomp++; $display("FAIL rst_nobusy: got %b expected 0", saw_busy); end
        vec++; if (dout2 !== 32'h0) begin miscomp++; $display("FAIL rst_dout: got %h expected 00000000", dout2); end
        access(1'b0, 1'b0, 32'h0000_0040, 32'h0, 1'b0, rd, lat, bc, e);
        vec++; if (rd !== 32'h1234_5678) begin miscomp++; $display("FAIL rst_ld40: got %h expected 12345678", rd); end
    endtask

    task automatic test_wrap_w0();
        logic [31:0] rd; int lat, bc; logic e;
        access(1'b1, 1'b1, 32'h0000_1004, 32'hA5A5_A5A5, 1'b0, rd, lat, bc, e);
        vec++; if (lat !== 1) begin miscomp++; $display("FAIL w0_st_lat: got %0d expected 1", lat); end
        vec++; if (bc !== 2) begin miscomp++; $display("FAIL w0_st_busy: got %0d expected 2", bc); end
        access(1'b1, 1'b0, 32'h0000_0004, 32'h0, 1'b0, rd, lat, bc, e);
        vec++; if (lat !== 1) begin miscomp++; $display("FAIL w0_ld_lat: got %0d expected 1", lat); end
        vec++; if (rd !== 32'hA5A5_A5A5) begin miscomp++; $display("FAIL wrap_ld: got %h expected a5a5a5a5", rd); end
    endtask

    task automatic test_back_to_back();
        logic exp_ack;
        @(posedge clock); #1;
        we = 1'b0; address = 32'h0000_0004; req0 = 1'b1;
        @(posedge clock);
        for (int n = 1; n <= 12; n++) begin
            @(negedge clock);
            exp_ack = ((n % 3) == 2);
            vec++;
            if (ack0 !== exp_ack) begin
                miscomp++;
                $display("FAIL b2b_ack cyc %0d: got %b expected %b", n, ack0, exp_ack);
            end
            if (exp_ack) begin
                vec++;
                if (dout0 !== 32'hA5A5_A5A5) begin
                    miscomp++;
                    $display("FAIL b2b_data cyc %0d: got %h expected a5a5a5a5", n, dout0);
                end
            end
        end
        req0 = 1'b0;
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic test_align();
        logic [31:0] rd; int lat, bc; logic e;
        access(1'b0, 1'b1, 32'h0000_0013, 32'h0BAD_F00D, 1'b0, rd, lat, bc, e);
`ifdef DM_ALIGN_CHECK_EN
        vec++; if (lat !== 0) begin miscomp++; $display("FAIL al_lat: got %0d expected 0", lat); end
        vec++; if (e !== 1'b1) begin miscomp++; $display("FAIL al_err: got %b expected 1", e); end
        vec++; if (rd !== 32'h1234_5678) begin miscomp++; $display("FAIL al_dout: got %h expected 12345678", rd); end
        @(negedge clock);
        vec++; if (err2 !== 1'b0) begin miscomp++; $display("FAIL al_err_clr: got %b expected 0", err2); end
        access(1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b0, rd, lat, bc, e);
        vec++; if (rd !== 32'hDEAD_BEEF) begin miscomp++; $display("FAIL al_ld10: got %h expected deadbeef", rd); end
`else
        vec++; if (lat !== 3) begin miscomp++; $display("FAIL al_lat: got %0d expected 3", lat); end
        vec++; if (e !== 1'b0) begin miscomp++; $display("FAIL al_err: got %b expected 0", e); end
        access(1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b0, rd, lat, bc, e);
        vec++; if (rd !== 32'h0BAD_F00D) begin miscomp++; $display("FAIL al_ld10: got %h expected 0badf00d", rd); end
`endif
        vec++; if (e !== 1'b0) begin miscomp++; $display("FAIL al_ld_err: got %b expected 0", e); end
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        test_reset();
        test_store_load();
        test_input_change();
        test_reset_during_wait();
        test_wrap_w0();
        test_back_to_back();
        test_align();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscomp);
        $finish;
    end

endmodule
